// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and FSM state type for the binary-to-BCD converter
package bcd_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_INC    = 4'd3;
    localparam logic [3:0] XS3_BIAS    = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } b2b_state_t;

endpackage

// File: rtl/bcd_add3_cell.sv
// rtl/bcd_add3_cell.sv - one-digit double-dabble correction: add 3 when the digit is 5 or more
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_i,
    output logic [DIGIT_W-1:0] q_o
);

    // 4-bit add with the carry dropped; inputs above 9 never occur in a legal conversion
    assign q_o = (d_i >= ADD3_THRESH) ? (d_i + ADD3_INC) : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock; optional out_xs3 via BIN2BCD_XS3_OUT_EN
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_W-1:0]          in_bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] out_bcd
`ifdef BIN2BCD_XS3_OUT_EN
    ,
    output logic [DIGIT_W*DIGITS-1:0] out_xs3
`endif
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // The BCD field must be able to represent the largest binary input
    if ((10 ** DIGITS) <= ((2 ** BIN_W) - 1)) begin : g_digits_check
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    b2b_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIN_W-1:0] bin_sr_q;
    logic [BCD_W-1:0] bcd_sr_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_sr_d;
    logic [BIN_W-1:0] bin_sr_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [BCD_W-1:0] out_bcd_q;

    // Per-digit add-3 correction applied before every shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_cell u_add3 (
            .d_i (bcd_sr_q[g*DIGIT_W +: DIGIT_W]),
            .q_o (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Shift the corrected BCD field and the binary field as one word; the top bit falls off
    assign {bcd_sr_d, bin_sr_d} = {bcd_adj, bin_sr_q} << 1;

`ifdef BIN2BCD_XS3_OUT_EN
    logic [BCD_W-1:0] xs3_d;
    logic [BCD_W-1:0] out_xs3_q;

    // Excess-3 form of the final BCD word, captured alongside out_bcd
    for (genvar g = 0; g < DIGITS; g++) begin : g_xs3
        assign xs3_d[g*DIGIT_W +: DIGIT_W] = bcd_sr_d[g*DIGIT_W +: DIGIT_W] + XS3_BIAS;
    end

    assign out_xs3 = out_xs3_q;
`endif

    // Control FSM with datapath registers; outputs are registered and held through DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bin_sr_q    <= '0;
            bcd_sr_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
`ifdef BIN2BCD_XS3_OUT_EN
            out_xs3_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        bin_sr_q   <= in_bin;
                        bcd_sr_q   <= '0;
                        cnt_q      <= CNT_W'(BIN_W);
                        in_ready_q <= 1'b0;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_sr_q <= bcd_sr_d;
                    bin_sr_q <= bin_sr_d;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        out_bcd_q   <= bcd_sr_d;
`ifdef BIN2BCD_XS3_OUT_EN
                        out_xs3_q   <= xs3_d;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // New accept is only possible from IDLE, so the handoff costs one cycle
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq with a decimal reference model
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BIN_W-1:0] in_bin = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BCD_W-1:0] out_bcd;
`ifdef BIN2BCD_XS3_OUT_EN
    logic [BCD_W-1:0] out_xs3;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd)
`ifdef BIN2BCD_XS3_OUT_EN
        ,
        .out_xs3   (out_xs3)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    // Decimal digits by repeated division, units in the low nibble
    function automatic logic [BCD_W-1:0] ref_bcd(input int v);
        logic [BCD_W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] ref_xs3(input int v);
        logic [BCD_W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'((t % 10) + 3);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present one word, then wait for out_valid; lat = edges from accept to out_valid, -1 on timeout
    task automatic convert(input logic [BIN_W-1:0] v, output logic [BCD_W-1:0] bcd, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        in_valid = 1'b1;
        in_bin   = v;
        tick();
        in_valid = 1'b0;
        in_bin   = BIN_W'($urandom);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        bcd = out_bcd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (out_bcd !== '0) begin n_fail++; $display("FAIL reset_out_bcd: got %h expected 000", out_bcd); end
`ifdef BIN2BCD_XS3_OUT_EN
        n_tests++;
        if (out_xs3 !== '0) begin n_fail++; $display("FAIL reset_out_xs3: got %h expected 000", out_xs3); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_max_value();
        logic [BCD_W-1:0] bcd;
        int lat;
        out_ready = 1'b1;
        convert(8'd255, bcd, lat);
        n_tests++;
        if (lat !== BIN_W) begin n_fail++; $display("FAIL max_latency: got %0d expected %0d", lat, BIN_W); end
        n_tests++;
        if (bcd !== ref_bcd(255)) begin n_fail++; $display("FAIL max_bcd: got %h expected %h", bcd, ref_bcd(255)); end
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL max_in_ready_done: got %b expected 0", in_ready); end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL max_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_edges();
        logic [BIN_W-1:0] vals [3];
        logic [BCD_W-1:0] bcd;
        int lat;
        vals[0] = 8'd0; vals[1] = 8'd10; vals[2] = 8'd99;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            convert(vals[i], bcd, lat);
            n_tests++;
            if (bcd !== ref_bcd(int'(vals[i])) || lat !== BIN_W) begin
                n_fail++;
                $display("FAIL edge_%0d: got %h lat %0d expected %h lat %0d", vals[i], bcd, lat, ref_bcd(int'(vals[i])), BIN_W);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [BCD_W-1:0] bcd;
        int lat;
        int bad;
        out_ready = 1'b0;
        convert(8'd137, bcd, lat);
        n_tests++;
        if (bcd !== ref_bcd(137)) begin n_fail++; $display("FAIL hold_value: got %h expected %h", bcd, ref_bcd(137)); end
        in_valid = 1'b1;
        in_bin   = 8'd42;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_bcd !== ref_bcd(137) || in_ready !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_ignore_busy();
        int lat;
        out_ready = 1'b1;
        in_valid = 1'b1; in_bin = 8'd137;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        in_valid = 1'b1; in_bin = 8'd42;
        lat = -1;
        for (int k = 3; k <= 30; k++) begin
            tick();
            if (out_valid) begin lat = k; break; end
        end
        n_tests++;
        if (out_bcd !== ref_bcd(137) || lat !== BIN_W) begin
            n_fail++;
            $display("FAIL ignore_first: got %h lat %0d expected %h lat %0d", out_bcd, lat, ref_bcd(137), BIN_W);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (out_valid) begin lat = k; break; end
        end
        n_tests++;
        if (out_bcd !== ref_bcd(42) || lat !== BIN_W) begin
            n_fail++;
            $display("FAIL ignore_represent: got %h lat %0d expected %h lat %0d", out_bcd, lat, ref_bcd(42), BIN_W);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [BCD_W-1:0] bcd;
        int lat;
        int spurious;
        out_ready = 1'b1;
        in_valid = 1'b1; in_bin = 8'd200;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: got out_valid=%b in_ready=%b out_bcd=%h expected 0/1/000", out_valid, in_ready, out_bcd);
        end
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) spurious++;
        end
        n_tests++;
        if (spurious != 0) begin n_fail++; $display("FAIL midreset_partial: got %0d valid cycles expected 0", spurious); end
        convert(8'd7, bcd, lat);
        n_tests++;
        if (bcd !== ref_bcd(7) || lat !== BIN_W) begin
            n_fail++;
            $display("FAIL midreset_after: got %h lat %0d expected %h lat %0d", bcd, lat, ref_bcd(7), BIN_W);
        end
        tick();
    endtask

    task automatic test_random();
        logic [BIN_W-1:0] v;
        logic [BCD_W-1:0] bcd;
        int lat;
        int stall;
        int bad;
        for (int i = 0; i < 30; i++) begin
            v = BIN_W'($urandom_range(0, 255));
            out_ready = 1'b0;
            convert(v, bcd, lat);
            n_tests++;
            if (bcd !== ref_bcd(int'(v)) || lat !== BIN_W) begin
                n_fail++;
                $display("FAIL random_%0d: in %0d got %h lat %0d expected %h lat %0d", i, v, bcd, lat, ref_bcd(int'(v)), BIN_W);
            end
`ifdef BIN2BCD_XS3_OUT_EN
            n_tests++;
            if (out_xs3 !== ref_xs3(int'(v))) begin
                n_fail++;
                $display("FAIL random_xs3_%0d: in %0d got %h expected %h", i, v, out_xs3, ref_xs3(int'(v)));
            end
`endif
            stall = $urandom_range(0, 3);
            bad = 0;
            for (int s = 0; s < stall; s++) begin
                tick();
                if (out_valid !== 1'b1 || out_bcd !== ref_bcd(int'(v))) bad++;
            end
            n_tests++;
            if (bad != 0) begin n_fail++; $display("FAIL random_stall_%0d: got %0d bad cycles expected 0", i, bad); end
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [BIN_W-1:0] vals [4];
        int out_cyc [4];
        int n_acc;
        int n_out;
        int bad;
        logic rdy;
        for (int i = 0; i < 4; i++) vals[i] = BIN_W'($urandom);
        n_acc = 0; n_out = 0; bad = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bin    = vals[0];
        for (int k = 0; k < 80 && n_out < 4; k++) begin
            rdy = in_ready;
            tick();
            if (rdy && in_valid) begin
                n_acc++;
                if (n_acc < 4) in_bin = vals[n_acc];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (out_bcd !== ref_bcd(int'(vals[n_out]))) bad++;
                out_cyc[n_out] = cyc;
                n_out++;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (n_out != 4 || bad != 0) begin
            n_fail++;
            $display("FAIL b2b_results: got %0d results %0d wrong expected 4 results 0 wrong", n_out, bad);
        end
        for (int i = 1; i < 4; i++) begin
            n_tests++;
            if (i < n_out && (out_cyc[i] - out_cyc[i-1]) != BIN_W + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing_%0d: got %0d cycles expected %0d", i, out_cyc[i] - out_cyc[i-1], BIN_W + 2);
            end else if (i >= n_out) begin
                n_fail++;
                $display("FAIL b2b_spacing_%0d: got missing result expected spacing %0d", i, BIN_W + 2);
            end
        end
        tick();
        out_ready = 1'b0;
    endtask

`ifdef BIN2BCD_XS3_OUT_EN
    task automatic test_xs3();
        logic [BCD_W-1:0] bcd;
        int lat;
        out_ready = 1'b0;
        convert(8'd9, bcd, lat);
        n_tests++;
        if (bcd !== ref_bcd(9) || out_xs3 !== ref_xs3(9)) begin
            n_fail++;
            $display("FAIL xs3_nine: got bcd %h xs3 %h expected %h %h", bcd, out_xs3, ref_bcd(9), ref_xs3(9));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_max_value();
        test_edges();
        test_hold();
        test_ignore_busy();
        test_reset_mid();
`ifdef BIN2BCD_XS3_OUT_EN
        test_xs3();
`endif
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
